multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multicycle MIPS main control FSM and ALU-operation encoder: the initiator side of the ALU's operation interface. It decodes the opcode and funct fields latched in the instruction register and sequences fetch, decode, execute, memory and write-back, one state per cycle. Each cycle it drives the ALU operation code, datapath mux selects, and register, PC and memory enables. It sits between the instruction register and the shared datapath, and its `alu_operation_o` feeds the ALU directly.

## Interface
Parameters: none.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `opcode_i` in 6: instruction[31:26].
- `funct_i` in 6: instruction[5:0].
- `zero_i` in 1: ALU `zero_o`.
- `mem_ready_i` in 1: memory access completes this cycle.
- `alu_operation_o` out 4: ADD=0011, SUB=0001, OR=0010, LUI=0100, idle=0000.
- `alu_src_a_o` out 1: 0=PC, 1=register A.
- `alu_src_b_o` out 2: 00=register B, 01=constant 4, 10=extended imm, 11=sign-ext imm<<2.
- `zero_ext_o` out 1: 1 selects zero-extension of the immediate (ori).
- `i_or_d_o` out 1: memory address, 0=PC, 1=ALUOut.
- `mem_read_o` out 1: memory read request.
- `mem_write_o` out 1: memory write request.
- `ir_write_o` out 1: load the instruction register.
- `reg_dst_o` out 1: destination register, 0=rt, 1=rd.
- `mem_to_reg_o` out 1: write-back data, 0=ALUOut, 1=MDR.
- `reg_write_o` out 1: register file write enable.
- `pc_source_o` out 2: 00=ALU result, 01=ALUOut, 10=jump target.
- `pc_en_o` out 1: PC write enable (already qualified by the branch condition).
- `illegal_o` out 1: one-cycle pulse on an unsupported instruction.
- `state_o` out 4: current state, for debug.

## Operation
- States and encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, I_EXEC=8, I_WB=9, BRANCH=10, JUMP=11.
- Unused state encodings go to FETCH on the next edge.
- Outputs are combinational from the state (Moore), with three exceptions:
  - `ir_write_o` and `pc_en_o` depend on `mem_ready_i` in FETCH.
  - `pc_en_o` depends on `zero_i` in BRANCH.
  - `illegal_o` depends on the decode in DECODE.
- Any output not listed for a state is 0.
- FETCH:
  - Drives mem_read=1, i_or_d=0, src_a=0, src_b=01, op=ADD, pc_source=00.
  - ir_write = pc_en = `mem_ready_i`.
  - Holds in FETCH until `mem_ready_i`, then goes to DECODE.
- DECODE:
  - Drives src_a=0, src_b=11, op=ADD (branch target into ALUOut).
  - Next state by opcode:
    - 0x00 with funct 0x20/0x22/0x25 → R_EXEC.
    - 0x08/0x0D/0x0F → I_EXEC.
    - 0x23/0x2B → MEM_ADDR.
    - 0x04 → BRANCH.
    - 0x02 → JUMP.
  - Any other opcode or funct: illegal=1, next state FETCH.
- MEM_ADDR: src_a=1, src_b=10, op=ADD. Next: lw → MEM_READ, sw → MEM_WRITE.
- MEM_READ: mem_read=1, i_or_d=1. Holds until `mem_ready_i`, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. Holds until `mem_ready_i`, then FETCH.
- R_EXEC: src_a=1, src_b=00, op from funct (0x20 ADD, 0x22 SUB, 0x25 OR). Next R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next FETCH.
- I_EXEC: src_a=1, src_b=10, op by opcode (addi ADD, ori OR with zero_ext=1, lui LUI). Next I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Next FETCH.
  - For ori, `zero_ext_o` is also held at 1 in I_WB.
- BRANCH: src_a=1, src_b=00, op=SUB, pc_source=01, pc_en=`zero_i` (beq). Next FETCH.
- JUMP: pc_source=10, pc_en=1. Next FETCH.
- `opcode_i` and `funct_i` are sampled in every state. The instruction register guarantees they are stable from DECODE onward.

## Timing
- Reset:
  - `reset` high at an edge sets state=FETCH. This applies from any state, including mid-access in MEM_READ or MEM_WRITE; the pending access is abandoned.
  - While `reset` is high, every output is forced to 0: `alu_operation_o`=0000, `state_o`=0, no mem_read, no ir_write, no pc_en.
- Latency in cycles with `mem_ready_i` high on the first request cycle:
  - lw 5; sw 4; R-type 4; addi/ori/lui 4; beq 3; j 3; illegal 2.
  - Each extra cycle with `mem_ready_i` low adds one cycle in FETCH, MEM_READ or MEM_WRITE.
- Memory handshake:
  - The request is held stable until the cycle in which `mem_ready_i`=1.
  - That cycle completes the access.
  - `mem_ready_i` is ignored in all other states.
- `illegal_o` is high for exactly one cycle, in DECODE.
- Two branch writes to the PC in one instruction are intended: PC+4 is written in FETCH, then the target in BRANCH if taken.

## Configuration
- `BNE_EN` defined:
  - opcode 0x05 in DECODE goes to BRANCH.
  - In BRANCH, pc_en=`!zero_i` for bne and `zero_i` for beq.
- `BNE_EN` undefined:
  - opcode 0x05 is illegal (`illegal_o` pulse, return to FETCH).
  - BRANCH handles beq only.

## Test plan
- Reset held 2 cycles mid-MEM_READ → `state_o`=0, all outputs 0 during reset; FETCH with mem_read=1 on the first cycle after release.
- add (op 0x00, funct 0x20), `mem_ready_i`=1 → states 0,1,6,7; `alu_operation_o`=0011 in R_EXEC; reg_write=1, reg_dst=1 in R_WB.
- lw (0x23) with `mem_ready_i` low 3 cycles in MEM_READ → MEM_READ held 4 cycles, `mem_read_o`=1, `i_or_d_o`=1 throughout; then MEM_WB with mem_to_reg=1.
- beq (0x04):
  - `zero_i`=1 → pc_en=1, pc_source=01, op=0001.
  - `zero_i`=0 → pc_en=0.
  - Both cases return to FETCH after 3 cycles.
- lui (0x0F) → `alu_operation_o`=0100 in I_EXEC. ori (0x0D) → op=0010 and `zero_ext_o`=1.
- opcode 0x3F, and funct 0x21 under op 0x00 → `illegal_o` pulses 1 cycle in DECODE; state 0 next; no reg/mem write asserted.
  - Also opcode 0x05: pulses illegal without `BNE_EN`; branches on `zero_i`=0 with it.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM and ALU-operation encoder (Moore outputs, one state per cycle).
// Optional feature: define BNE_EN to route opcode 0x05 (bne) through BRANCH with an inverted zero test.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic [3:0] alu_operation_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic       zero_ext_o,
  output logic       i_or_d_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic [1:0] pc_source_o,
  output logic       pc_en_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_R_EXEC    = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_I_EXEC    = 4'd8;
  localparam logic [3:0] S_I_WB      = 4'd9;
  localparam logic [3:0] S_BRANCH    = 4'd10;
  localparam logic [3:0] S_JUMP      = 4'd11;

  localparam logic [3:0] ALU_IDLE = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0010;
  localparam logic [3:0] ALU_ADD  = 4'b0011;
  localparam logic [3:0] ALU_LUI  = 4'b0100;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
`ifdef BNE_EN
  localparam logic [5:0] OP_BNE   = 6'h05;
`endif

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_OR  = 6'h25;

  logic [3:0] r_state;
  logic [3:0] w_next;

  // State register; reset abandons any pending memory access.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Next state and Moore outputs; reset forces every output low.
  always_comb begin
    w_next          = S_FETCH;
    alu_operation_o = ALU_IDLE;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = 2'b00;
    zero_ext_o      = 1'b0;
    i_or_d_o        = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    reg_dst_o       = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_write_o     = 1'b0;
    pc_source_o     = 2'b00;
    pc_en_o         = 1'b0;
    illegal_o       = 1'b0;
    state_o         = r_state;

    case (r_state)
      S_FETCH: begin
        mem_read_o      = 1'b1;
        alu_src_b_o     = 2'b01;
        alu_operation_o = ALU_ADD;
        ir_write_o      = mem_ready_i;
        pc_en_o         = mem_ready_i;
        w_next          = mem_ready_i ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b_o     = 2'b11;
        alu_operation_o = ALU_ADD;
        case (opcode_i)
          OP_RTYPE: begin
            if (funct_i == FN_ADD || funct_i == FN_SUB || funct_i == FN_OR) w_next = S_R_EXEC;
            else illegal_o = 1'b1;
          end
          OP_ADDI, OP_ORI, OP_LUI: w_next = S_I_EXEC;
          OP_LW, OP_SW:            w_next = S_MEM_ADDR;
          OP_BEQ:                  w_next = S_BRANCH;
`ifdef BNE_EN
          OP_BNE:                  w_next = S_BRANCH;
`endif
          OP_J:                    w_next = S_JUMP;
          default:                 illegal_o = 1'b1;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a_o     = 1'b1;
        alu_src_b_o     = 2'b10;
        alu_operation_o = ALU_ADD;
        if (opcode_i == OP_LW)      w_next = S_MEM_READ;
        else if (opcode_i == OP_SW) w_next = S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_read_o = 1'b1;
        i_or_d_o   = 1'b1;
        w_next     = mem_ready_i ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write_o = 1'b1;
        i_or_d_o    = 1'b1;
        w_next      = mem_ready_i ? S_FETCH : S_MEM_WRITE;
      end
      S_R_EXEC: begin
        alu_src_a_o = 1'b1;
        w_next      = S_R_WB;
        case (funct_i)
          FN_ADD:  alu_operation_o = ALU_ADD;
          FN_SUB:  alu_operation_o = ALU_SUB;
          FN_OR:   alu_operation_o = ALU_OR;
          default: alu_operation_o = ALU_IDLE;
        endcase
      end
      S_R_WB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
      end
      S_I_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        w_next      = S_I_WB;
        case (opcode_i)
          OP_ADDI: alu_operation_o = ALU_ADD;
          OP_ORI: begin
            alu_operation_o = ALU_OR;
            zero_ext_o      = 1'b1;
          end
          OP_LUI:  alu_operation_o = ALU_LUI;
          default: alu_operation_o = ALU_IDLE;
        endcase
      end
      S_I_WB: begin
        reg_write_o = 1'b1;
        zero_ext_o  = (opcode_i == OP_ORI);
      end
      S_BRANCH: begin
        alu_src_a_o     = 1'b1;
        alu_operation_o = ALU_SUB;
        pc_source_o     = 2'b01;
`ifdef BNE_EN
        pc_en_o         = (opcode_i == OP_BNE) ? ~zero_i : zero_i;
`else
        pc_en_o         = zero_i;
`endif
      end
      S_JUMP: begin
        pc_source_o = 2'b10;
        pc_en_o     = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase

    if (reset) begin
      alu_operation_o = ALU_IDLE;
      alu_src_a_o     = 1'b0;
      alu_src_b_o     = 2'b00;
      zero_ext_o      = 1'b0;
      i_or_d_o        = 1'b0;
      mem_read_o      = 1'b0;
      mem_write_o     = 1'b0;
      ir_write_o      = 1'b0;
      reg_dst_o       = 1'b0;
      mem_to_reg_o    = 1'b0;
      reg_write_o     = 1'b0;
      pc_source_o     = 2'b00;
      pc_en_o         = 1'b0;
      illegal_o       = 1'b0;
      state_o         = 4'd0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: a per-instruction cycle plan is built from the
// instruction class, the driver plays it and queues the expected control word, a monitor checks.
module tb_multicycle_control;

  logic       clk = 1'b1;
  logic       reset;
  logic [5:0] opcode_i, funct_i;
  logic       zero_i, mem_ready_i;
  logic [3:0] alu_operation_o;
  logic       alu_src_a_o;
  logic [1:0] alu_src_b_o;
  logic       zero_ext_o, i_or_d_o, mem_read_o, mem_write_o, ir_write_o;
  logic       reg_dst_o, mem_to_reg_o, reg_write_o;
  logic [1:0] pc_source_o;
  logic       pc_en_o, illegal_o;
  logic [3:0] state_o;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode_i(opcode_i), .funct_i(funct_i),
    .zero_i(zero_i), .mem_ready_i(mem_ready_i),
    .alu_operation_o(alu_operation_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
    .zero_ext_o(zero_ext_o), .i_or_d_o(i_or_d_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .ir_write_o(ir_write_o), .reg_dst_o(reg_dst_o),
    .mem_to_reg_o(mem_to_reg_o), .reg_write_o(reg_write_o), .pc_source_o(pc_source_o),
    .pc_en_o(pc_en_o), .illegal_o(illegal_o), .state_o(state_o)
  );

  typedef struct packed {
    logic [3:0] alu;
    logic       sa;
    logic [1:0] sb;
    logic       zx, iord, mrd, mwr, irw, rdst, m2r, rwr;
    logic [1:0] pcs;
    logic       pcen, ill;
    logic [3:0] st;
  } vec_t;

  typedef struct {
    logic       rst, rdy, z;
    logic [5:0] op, fn;
    vec_t       e;
  } step_t;

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BR = 4, K_J = 5, K_ILL = 6;

  step_t plan[$];
  vec_t  sbq[$];
  int    errors = 0;
  int    checks = 0;

  function automatic vec_t zv(input logic [3:0] st);
    vec_t v;
    v = '0;
    v.st = st;
    return v;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Instruction classes of the supported MIPS subset.
  function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) return (fn == 6'h20 || fn == 6'h22 || fn == 6'h25) ? K_R : K_ILL;
    if (op == 6'h08 || op == 6'h0D || op == 6'h0F) return K_I;
    if (op == 6'h23) return K_LW;
    if (op == 6'h2B) return K_SW;
    if (op == 6'h04) return K_BR;
`ifdef BNE_EN
    if (op == 6'h05) return K_BR;
`endif
    if (op == 6'h02) return K_J;
    return K_ILL;
  endfunction

  task automatic push(input logic rst, input logic rdy, input logic z,
                      input logic [5:0] op, input logic [5:0] fn, input vec_t e);
    step_t s;
    s.rst = rst; s.rdy = rdy; s.z = z; s.op = op; s.fn = fn; s.e = e;
    plan.push_back(s);
  endtask

  task automatic gen_reset(input int n);
    for (int i = 0; i < n; i++) push(1'b1, rb(), rb(), 6'($urandom), 6'($urandom), zv(4'd0));
  endtask

  // abort>=0: lw is cut short by a 2-cycle reset after that many not-ready MEM_READ cycles.
  task automatic gen(input logic [5:0] op, input logic [5:0] fn, input int fwait,
                     input int mwait, input logic zbr, input int abort);
    vec_t e;
    int   k;
    k = kind_of(op, fn);
    for (int i = 0; i <= fwait; i++) begin
      e = zv(4'd0); e.alu = 4'b0011; e.sb = 2'b01; e.mrd = 1'b1;
      e.irw = (i == fwait); e.pcen = (i == fwait);
      push(1'b0, (i == fwait), rb(), op, fn, e);
    end
    e = zv(4'd1); e.sb = 2'b11; e.alu = 4'b0011; e.ill = (k == K_ILL);
    push(1'b0, rb(), rb(), op, fn, e);
    case (k)
      K_LW, K_SW: begin
        e = zv(4'd2); e.sa = 1'b1; e.sb = 2'b10; e.alu = 4'b0011;
        push(1'b0, rb(), rb(), op, fn, e);
        if (abort >= 0) begin
          for (int i = 0; i < abort; i++) begin
            e = zv(4'd3); e.mrd = 1'b1; e.iord = 1'b1;
            push(1'b0, 1'b0, rb(), op, fn, e);
          end
          push(1'b1, 1'b1, rb(), op, fn, zv(4'd0));
          push(1'b1, 1'b0, rb(), op, fn, zv(4'd0));
        end else begin
          for (int i = 0; i <= mwait; i++) begin
            e = zv((k == K_LW) ? 4'd3 : 4'd5); e.iord = 1'b1;
            if (k == K_LW) e.mrd = 1'b1; else e.mwr = 1'b1;
            push(1'b0, (i == mwait), rb(), op, fn, e);
          end
          if (k == K_LW) begin
            e = zv(4'd4); e.rwr = 1'b1; e.m2r = 1'b1;
            push(1'b0, rb(), rb(), op, fn, e);
          end
        end
      end
      K_R: begin
        e = zv(4'd6); e.sa = 1'b1;
        e.alu = (fn == 6'h20) ? 4'b0011 : (fn == 6'h22) ? 4'b0001 : 4'b0010;
        push(1'b0, rb(), rb(), op, fn, e);
        e = zv(4'd7); e.rwr = 1'b1; e.rdst = 1'b1;
        push(1'b0, rb(), rb(), op, fn, e);
      end
      K_I: begin
        e = zv(4'd8); e.sa = 1'b1; e.sb = 2'b10; e.zx = (op == 6'h0D);
        e.alu = (op == 6'h08) ? 4'b0011 : (op == 6'h0D) ? 4'b0010 : 4'b0100;
        push(1'b0, rb(), rb(), op, fn, e);
        e = zv(4'd9); e.rwr = 1'b1; e.zx = (op == 6'h0D);
        push(1'b0, rb(), rb(), op, fn, e);
      end
      K_BR: begin
        e = zv(4'd10); e.sa = 1'b1; e.alu = 4'b0001; e.pcs = 2'b01;
        e.pcen = (op == 6'h05) ? ~zbr : zbr;
        push(1'b0, rb(), zbr, op, fn, e);
      end
      K_J: begin
        e = zv(4'd11); e.pcs = 2'b10; e.pcen = 1'b1;
        push(1'b0, rb(), rb(), op, fn, e);
      end
      default: ;
    endcase
  endtask

  task automatic pick(output logic [5:0] op, output logic [5:0] fn);
    logic [5:0] ops [11];
    int         i;
    ops = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h08, 6'h0D, 6'h0F, 6'h04, 6'h05, 6'h02, 6'h3F};
    i  = int'($urandom_range(0, 11));
    op = (i == 11) ? 6'($urandom) : ops[i];
    case ($urandom_range(0, 3))
      0:       fn = 6'h20;
      1:       fn = 6'h22;
      2:       fn = 6'h25;
      default: fn = 6'($urandom);
    endcase
  endtask

  // Monitor: the controller presents a control word every cycle.
  always @(negedge clk) begin
    vec_t a, x;
    if (sbq.size() != 0) begin
      x = sbq.pop_front();
      a = '{alu_operation_o, alu_src_a_o, alu_src_b_o, zero_ext_o, i_or_d_o, mem_read_o,
            mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o, reg_write_o, pc_source_o,
            pc_en_o, illegal_o, state_o};
      checks++;
      if (a !== x) begin
        errors++;
        $display("FAIL ctrl_word t=%0t: got st=%0d word=%h, want st=%0d word=%h",
                 $time, a.st, a, x.st, x);
      end
    end
  end

  initial begin
    logic [5:0] op, fn;
    step_t      s;
    reset = 1'b1; mem_ready_i = 1'b0; zero_i = 1'b0; opcode_i = '0; funct_i = '0;

    gen_reset(2);
    gen(6'h00, 6'h20, 0, 0, 1'b0, -1);
    gen(6'h23, 6'h00, 0, 3, 1'b0, -1);
    gen(6'h04, 6'h00, 0, 0, 1'b1, -1);
    gen(6'h04, 6'h00, 0, 0, 1'b0, -1);
    gen(6'h0F, 6'h00, 0, 0, 1'b0, -1);
    gen(6'h0D, 6'h00, 0, 0, 1'b0, -1);
    gen(6'h3F, 6'h00, 0, 0, 1'b0, -1);
    gen(6'h00, 6'h21, 0, 0, 1'b0, -1);
    gen(6'h05, 6'h00, 0, 0, 1'b0, -1);
    gen(6'h2B, 6'h00, 2, 2, 1'b0, -1);
    gen(6'h02, 6'h00, 1, 0, 1'b0, -1);
    gen(6'h08, 6'h00, 0, 0, 1'b0, -1);
    gen(6'h00, 6'h22, 0, 0, 1'b0, -1);
    gen(6'h00, 6'h25, 0, 0, 1'b0, -1);
    gen(6'h23, 6'h00, 0, 0, 1'b0, 1);
    for (int n = 0; n < 150; n++) begin
      pick(op, fn);
      gen(op, fn, ($urandom_range(0, 1) != 0) ? 0 : int'($urandom_range(1, 3)),
          int'($urandom_range(0, 3)), rb(), -1);
      if (n % 50 == 25) gen_reset(1);
    end

    while (plan.size() != 0) begin
      s = plan.pop_front();
      reset = s.rst; mem_ready_i = s.rdy; zero_i = s.z; opcode_i = s.op; funct_i = s.fn;
      sbq.push_back(s.e);
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d words left unchecked, want 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
